// File: rtl/if_fetch_bpred.sv
// Instruction-fetch stage: owns the fetch PC and a direct-mapped BTB with 2-bit counters.
// Define IF_BPRED_EN to build the BTB; without it the stage fetches sequentially (plus redirect/stall).
module if_fetch_bpred #(
    parameter int          BTB_ENTRIES = 8,
    parameter logic [15:0] RESET_PC    = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] pc_out,
    output logic [15:0] pc_next_out,
    output logic [15:0] instr_out,
    output logic        spec_taken_out,
    input  logic        upd_valid,
    input  logic [15:0] upd_pc,
    input  logic [15:0] upd_target,
    input  logic        upd_taken
);

    localparam int IDX  = $clog2(BTB_ENTRIES);
    localparam int TAGW = 16 - IDX;

    logic [15:0] pc_q;
    logic [15:0] pc_d;
    logic [15:0] pc_inc;
    logic        spec_taken;
    logic [15:0] pred_target;

    assign pc_inc      = pc_q + 16'd1;
    assign imem_addr   = pc_q;
    assign pc_out      = pc_q;
    assign pc_next_out = pc_inc;
    assign instr_out   = imem_data;

`ifdef IF_BPRED_EN

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    logic            btb_valid  [BTB_ENTRIES];
    logic [TAGW-1:0] btb_tag    [BTB_ENTRIES];
    logic [15:0]     btb_target [BTB_ENTRIES];
    logic [1:0]      btb_ctr    [BTB_ENTRIES];

    logic [IDX-1:0]  look_idx;
    logic [TAGW-1:0] look_tag;
    logic            look_hit;
    logic [IDX-1:0]  upd_idx;
    logic [TAGW-1:0] upd_tag;
    logic            upd_hit;

    assign look_idx = pc_q[IDX-1:0];
    assign look_tag = pc_q[15:IDX];
    assign look_hit = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);

    assign spec_taken  = look_hit && btb_ctr[look_idx][1];
    assign pred_target = btb_target[look_idx];

    assign upd_idx = upd_pc[IDX-1:0];
    assign upd_tag = upd_pc[15:IDX];
    assign upd_hit = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);

    // Training writes land on the edge, so a same-cycle lookup sees the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_ctr[i]    <= 2'b01;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    btb_ctr[upd_idx]    <= sat_inc(btb_ctr[upd_idx]);
                    btb_target[upd_idx] <= upd_target;
                end else begin
                    btb_ctr[upd_idx] <= sat_dec(btb_ctr[upd_idx]);
                end
            end else if (upd_taken) begin
                btb_valid[upd_idx]  <= 1'b1;
                btb_tag[upd_idx]    <= upd_tag;
                btb_target[upd_idx] <= upd_target;
                btb_ctr[upd_idx]    <= 2'b10;
            end
        end
    end

`else

    logic unused_upd;

    assign spec_taken  = 1'b0;
    assign pred_target = pc_inc;
    assign unused_upd  = ^{upd_valid, upd_pc, upd_target, upd_taken};

`endif

    assign spec_taken_out = spec_taken;

    always_comb begin
        pc_d = pc_inc;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (spec_taken) begin
            pc_d = pred_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_bpred.sv
// Scoreboard bench for if_fetch_bpred: a reference fetch/BTB model pushes expected outputs each cycle.
module tb_if_fetch_bpred;

`ifdef IF_BPRED_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] pc_out;
    logic [15:0] pc_next_out;
    logic [15:0] instr_out;
    logic        spec_taken_out;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic [15:0] upd_target;
    logic        upd_taken;

    always #5 clk = ~clk;

    // Memory model: data is a fixed scramble of the address.
    assign imem_data = imem_addr ^ 16'h5A3C;

    if_fetch_bpred #(.BTB_ENTRIES(8), .RESET_PC(16'h0010)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .pc_out(pc_out), .pc_next_out(pc_next_out), .instr_out(instr_out),
        .spec_taken_out(spec_taken_out),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken)
    );

    typedef struct {
        logic [15:0] pc;
        logic [15:0] nxt;
        logic [15:0] ins;
        logic        spec;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    logic [15:0] m_pc;
    logic        m_valid  [8];
    logic [12:0] m_tag    [8];
    logic [15:0] m_target [8];
    logic [1:0]  m_ctr    [8];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    function automatic logic m_spec();
        logic [2:0] i;
        i = m_pc[2:0];
        return BP && m_valid[i] && (m_tag[i] == m_pc[15:3]) && (m_ctr[i] >= 2'd2);
    endfunction

    task automatic model_reset();
        m_pc = 16'h0010;
        for (int i = 0; i < 8; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = '0;
            m_target[i] = '0;
            m_ctr[i]    = 2'b01;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; stall = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 16'h0777;
        upd_valid = 1'b1; upd_pc = 16'h0012; upd_target = 16'h0040; upd_taken = 1'b1;
        @(posedge clk);
        model_reset();
    endtask

    task automatic cyc(input logic st, input logic rv, input logic [15:0] rpc,
                       input logic uv, input logic [15:0] upc, input logic [15:0] utg,
                       input logic ut);
        exp_t e;
        exp_t g;
        logic sp;
        logic [2:0] ui;
        @(negedge clk);
        rst = 1'b0; stall = st; redirect_valid = rv; redirect_pc = rpc;
        upd_valid = uv; upd_pc = upc; upd_target = utg; upd_taken = ut;
        sp = m_spec();
        e.pc = m_pc; e.nxt = m_pc + 16'd1; e.ins = m_pc ^ 16'h5A3C; e.spec = sp;
        sb.push_back(e);
        #1;
        g = sb.pop_front();
        check("pc_out", pc_out, g.pc);
        check("imem_addr", imem_addr, g.pc);
        check("pc_next_out", pc_next_out, g.nxt);
        check("instr_out", instr_out, g.ins);
        check("spec_taken_out", {15'd0, spec_taken_out}, {15'd0, g.spec});
        @(posedge clk);
        if (rv)        m_pc = rpc;
        else if (st)   m_pc = m_pc;
        else if (sp)   m_pc = m_target[m_pc[2:0]];
        else           m_pc = m_pc + 16'd1;
        ui = upc[2:0];
        if (uv) begin
            if (m_valid[ui] && m_tag[ui] == upc[15:3]) begin
                if (ut) begin
                    if (m_ctr[ui] != 2'd3) m_ctr[ui] = m_ctr[ui] + 2'd1;
                    m_target[ui] = utg;
                end else if (m_ctr[ui] != 2'd0) begin
                    m_ctr[ui] = m_ctr[ui] - 2'd1;
                end
            end else if (ut) begin
                m_valid[ui] = 1'b1; m_tag[ui] = upc[15:3];
                m_target[ui] = utg; m_ctr[ui] = 2'b10;
            end
        end
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic go(input logic [15:0] a);
        cyc(1'b0, 1'b1, a, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic train(input logic [15:0] a, input logic [15:0] t, input logic tk);
        cyc(1'b0, 1'b0, 16'h0, 1'b1, a, t, tk);
    endtask

    initial begin
        do_reset();
        do_reset();
        repeat (3) idle();

        train(16'h0012, 16'h0040, 1'b1);
        go(16'h0012); idle(); idle();

        train(16'h0012, 16'h0040, 1'b0);
        train(16'h0012, 16'h0040, 1'b0);
        go(16'h0012); idle(); idle();

        repeat (4) train(16'h0012, 16'h0040, 1'b1);
        train(16'h0012, 16'h0040, 1'b0);
        go(16'h0012);
        cyc(1'b0, 1'b0, 16'h0, 1'b1, 16'h0012, 16'h0040, 1'b0);
        go(16'h0012); idle(); idle();

        train(16'h0012, 16'h0040, 1'b1);
        train(16'h001A, 16'h0080, 1'b1);
        go(16'h0012); idle(); idle();
        go(16'h001A); idle(); idle();

        train(16'h0020, 16'h0050, 1'b1);
        go(16'h0020);
        repeat (3) cyc(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
        cyc(1'b1, 1'b1, 16'h0100, 1'b0, 16'h0, 16'h0, 1'b0);
        idle();

        train(16'h0020, 16'h0060, 1'b1);
        go(16'h0020); idle(); idle();

        go(16'hFFFF); idle(); idle();

        for (int k = 0; k < 60; k++) begin
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                16'h0010 + 16'($urandom_range(0, 31)),
                $urandom_range(0, 1) == 1, 16'h0010 + 16'($urandom_range(0, 31)),
                16'h0010 + 16'($urandom_range(0, 31)), $urandom_range(0, 2) != 0);
        end

        do_reset();
        idle(); idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_bpred.md
Name: if_fetch_bpred

Overview:
- Instruction-fetch stage of the 16-bit pipelined core. Sits directly upstream of the IF/ID pipeline register.
- Owns the architectural fetch PC and drives the instruction-memory address.
- Produces PC, PC+1, the fetched instruction and a speculative-taken bit for IF/ID.
- Contains a small direct-mapped branch target buffer (BTB) with 2-bit saturating counters. The BTB is trained by the branch-resolution stage.

Parameters:
- BTB_ENTRIES, 8, number of BTB entries; power of two, 2..64; IDX = log2(BTB_ENTRIES)
- RESET_PC, 16'h0000, PC value loaded on reset

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  1  hold PC (IF/ID enable deasserted downstream)
- redirect_valid  input  1  mispredict/flush; load redirect_pc
- redirect_pc  input  16  corrected fetch address
- imem_addr  output  16  instruction-memory address (= PC register)
- imem_data  input  16  instruction word; combinational read, same cycle
- pc_out  output  16  PC of current fetch, to IF/ID PC_In
- pc_next_out  output  16  PC+1, to IF/ID PC_Next_In
- instr_out  output  16  fetched instruction, to IF/ID Instr_In
- spec_taken_out  output  1  1 = BTB predicted taken and fetch redirected, to IF/ID Spec_taken_in
- upd_valid  input  1  branch resolved this cycle; train BTB
- upd_pc  input  16  PC of resolved branch
- upd_target  input  16  resolved branch target
- upd_taken  input  1  resolved outcome

Behaviour:
- State:
  - PC register, 16 bits.
  - Per BTB entry: valid (1), tag (16-IDX), target (16), ctr (2).
- Index and tag:
  - index = PC[IDX-1:0]
  - tag = PC[15:IDX]
- Combinational outputs:
  - imem_addr = pc_out = PC
  - instr_out = imem_data
  - pc_next_out = PC+1, modulo 2^16 (16'hFFFF -> 16'h0000)
- Lookup:
  - hit = valid[index] && tag match.
  - spec_taken_out = hit && ctr[index] >= 2.
  - pred_target = target[index].
- Next-PC priority at each rising edge, highest first:
  1. rst: PC <= RESET_PC.
  2. redirect_valid: PC <= redirect_pc. Wins over stall.
  3. stall: PC holds.
  4. spec_taken_out: PC <= pred_target.
  5. else: PC <= PC+1.
- Reset:
  - PC = RESET_PC.
  - All valid = 0, all ctr = 2'b01.
  - Outputs after reset: pc_out = RESET_PC, pc_next_out = RESET_PC+1, spec_taken_out = 0.
  - instr_out follows imem_data.
  - rst overrides any in-flight upd_valid or redirect in the same cycle.
- BTB update, on the edge when upd_valid = 1 (u = upd_pc index):
  - Tag hit, upd_taken = 1: ctr <= sat_inc(ctr) (max 3); target <= upd_target.
  - Tag hit, upd_taken = 0: ctr <= sat_dec(ctr) (min 0). Entry stays valid; target unchanged.
  - Miss (invalid or tag mismatch), upd_taken = 1: allocate. valid = 1, tag, target = upd_target, ctr = 2'b10 (weakly taken). Replaces any prior occupant.
  - Miss, upd_taken = 0: no change.
- Update timing:
  - Updates occur regardless of stall or redirect.
  - A lookup in the same cycle as an update to the same entry sees the pre-update contents. The new value is visible from the next cycle.
- Latency:
  - Prediction is zero-cycle; a predicted-taken fetch's successor is fetched the next cycle at the target.
  - Training takes effect one cycle after upd_valid.

Optional Feature:
- Macro: IF_BPRED_EN
- Defined: BTB and prediction present as above.
- Undefined:
  - No BTB storage.
  - spec_taken_out is tied 0.
  - Next PC = redirect_pc / hold / PC+1 only.
  - upd_* inputs are ignored.
  - Port list is unchanged.

Test Plan:
- Reset with RESET_PC = 16'h0010, imem returns sequential words -> pc_out 0010, 0011, 0012 on successive cycles; pc_next_out = pc_out+1; spec_taken_out = 0.
- Upd_valid, upd_pc = 0x0012, upd_taken = 1, upd_target = 0x0040, then fetch reaches 0x0012 -> spec_taken_out = 1 at 0x0012; next pc_out = 0x0040.
- Same branch trained not-taken twice (ctr 2 -> 1 -> 0) -> at 0x0012, spec_taken_out = 0 and next pc_out = 0x0013. Then three taken updates -> ctr saturates at 3; a fourth taken update leaves 3.
- Aliasing with BTB_ENTRIES = 8: train 0x0012 taken, then train 0x001A taken to 0x0080 -> fetch at 0x0012 shows no hit (next 0x0013); fetch at 0x001A predicts 0x0080.
- Stall = 1 for 3 cycles at PC = 0x0020 with a predicted hit -> PC holds 0x0020. Redirect_valid with redirect_pc = 0x0100 during stall -> next pc_out = 0x0100.
- PC = 0xFFFF, no hit -> pc_next_out = 0x0000 and next pc_out = 0x0000. With IF_BPRED_EN undefined, repeat the taken-training test -> spec_taken_out stays 0 and the PC is sequential.
